// File: rtl/bus_sram_responder_if.sv
// Data-bus link between the LSU request/grant initiator and a memory-mapped responder.
// Initiator drives REQ/ADDR/WDATA/WE/RE/HB and holds REQ until GNT.
// Responder returns a one-cycle GNT with ERR and right-aligned RDATA.
interface bus_sram_responder_if;
  logic        i_BUS_REQ;
  logic [31:0] i_BUS_ADDR;
  logic [31:0] i_BUS_WDATA;
  logic        i_BUS_WE;
  logic        i_BUS_RE;
  logic [1:0]  i_BUS_HB;
  logic [31:0] o_BUS_RDATA;
  logic        o_BUS_GNT;
  logic        o_BUS_ERR;

  modport master (
    output i_BUS_REQ, i_BUS_ADDR, i_BUS_WDATA, i_BUS_WE, i_BUS_RE, i_BUS_HB,
    input  o_BUS_RDATA, o_BUS_GNT, o_BUS_ERR
  );

  modport slave (
    input  i_BUS_REQ, i_BUS_ADDR, i_BUS_WDATA, i_BUS_WE, i_BUS_RE, i_BUS_HB,
    output o_BUS_RDATA, o_BUS_GNT, o_BUS_ERR
  );
endinterface

// File: rtl/bus_sram_responder.sv
// Word SRAM on the LSU data bus, answering only requests inside its own address window.
// Latency: GNT is high WAIT_STATES+1 cycles after the request cycle; RDATA is registered with GNT.
// Backpressure: the initiator holds REQ until GNT; a REQ drop while waiting aborts without a write.
// Ports: i_CLK, i_RSTn (async active low), bus (slave modport carrying REQ/ADDR/WDATA/WE/RE/HB, RDATA/GNT/ERR).
module bus_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  bus_sram_responder_if.slave   bus
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_MASK = ~(32'(DEPTH_WORDS * 4) - 32'd1);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [1:0]    hb_q, hb_d;
  logic          gnt_q, gnt_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          hit;
  logic          enter_resp;
  logic          acc_err;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_lane;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wr_word;

  assign hit = (bus.i_BUS_ADDR & WIN_MASK) == BASE_ADDR;

  // Sequencing: capture the request, count wait states, then a single response cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    re_d       = re_q;
    hb_d       = hb_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_BUS_REQ && hit) begin
          addr_d  = bus.i_BUS_ADDR[AW+1:0];
          wdata_d = bus.i_BUS_WDATA;
          we_d    = bus.i_BUS_WE;
          re_d    = bus.i_BUS_RE;
          hb_d    = bus.i_BUS_HB;
          cnt_d   = WAIT_CNT;
          if (WAIT_STATES == 0) enter_resp = 1'b1;
          else                  state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Abort has priority over the final countdown step.
        if (!bus.i_BUS_REQ)      state_d    = ST_IDLE;
        else if (cnt_q == 4'd1)  enter_resp = 1'b1;
        else                     cnt_d      = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) state_d = ST_RESP;
  end

  // Response decode works on the *_d fields so a zero-wait-state request can be
  // answered from the bus values on the same edge that accepts it.
  always_comb begin
    acc_err = (hb_d == 2'b11)
           || (hb_d == 2'b01 && addr_d[0])
           || (hb_d == 2'b10 && addr_d[1:0] != 2'b00)
           || (we_d && re_d);
    rd_shift = mem[addr_d[AW+1:2]] >> {addr_d[1:0], 3'b000};
    case (hb_d)
      2'b00:   rd_lane = {24'd0, rd_shift[7:0]};
      2'b01:   rd_lane = {16'd0, rd_shift[15:0]};
      default: rd_lane = rd_shift;
    endcase
    gnt_d   = enter_resp;
    err_d   = enter_resp && acc_err;
    rdata_d = rdata_q;
    if (enter_resp) rdata_d = (re_d && !we_d && !acc_err) ? rd_lane : 32'd0;
  end

  // Write path: commits on the edge that leaves RESP, using the latched request.
  always_comb begin
    wr_en = (state_q == ST_RESP) && we_q && !re_q && !err_q;
    case (hb_q)
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << addr_q[1:0];
        wr_word = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = wdata_q;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      hb_q    <= 2'b00;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      hb_q    <= hb_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_CLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.o_BUS_GNT   = gnt_q;
  assign bus.o_BUS_ERR   = err_q;
  assign bus.o_BUS_RDATA = rdata_q;
endmodule
